// File: rtl/usb2_host_token_tx.sv
// usb2_host_token_tx
//   Host-side USB 2.0 token transmitter and response collector over ULPI.
//   Builds IN/OUT/SETUP/PING/SOF tokens (PID TX CMD, two payload bytes with
//   CRC5), pushes them through the ULPI transmit handshake and, for IN and
//   PING, waits for the first response byte or a bus-turnaround timeout.
//
// Valid/ready semantics on the ULPI transmit side: out_byte is offered while
// out_latch=1 and is consumed on any cycle where out_nxt=1; the byte and
// out_latch hold unchanged until that cycle. out_stp follows the last byte.
//
// Ports
//   phy_clk, reset                 60 MHz ULPI clock, async active-high reset
//   tok_req/pid/addr/endp/frame    token request (sampled in idle only)
//   tok_busy, tok_done             request in flight / completion pulse
//   err_bad_req                    pulse: request carried a non-token PID
//   out_cts, out_nxt               PHY bus free / PHY accepted out_byte
//   out_byte, out_latch, out_stp   transmit byte, byte valid, end of packet
//   in_act, in_byte, in_latch      PHY receive active / byte / byte valid
//   rsp_valid, rsp_pid, rsp_pid_err  captured response PID and check error
//   rsp_timeout                    pulse: no response (or empty response)
module usb2_host_token_tx #(
   parameter int RSP_TIMEOUT = 120,
   parameter int TIMEOUT_W   = 8
) (
   input  logic        phy_clk,
   input  logic        reset,
   input  logic        tok_req,
   input  logic [3:0]  tok_pid,
   input  logic [6:0]  tok_addr,
   input  logic [3:0]  tok_endp,
   input  logic [10:0] tok_frame,
   output logic        tok_busy,
   output logic        tok_done,
   output logic        err_bad_req,
   input  logic        out_cts,
   input  logic        out_nxt,
   output logic [7:0]  out_byte,
   output logic        out_latch,
   output logic        out_stp,
   input  logic        in_act,
   input  logic [7:0]  in_byte,
   input  logic        in_latch,
   output logic        rsp_valid,
   output logic [3:0]  rsp_pid,
   output logic        rsp_pid_err,
   output logic        rsp_timeout
);

   localparam logic [3:0] PID_OUT   = 4'hE;
   localparam logic [3:0] PID_IN    = 4'h6;
   localparam logic [3:0] PID_SOF   = 4'hA;
   localparam logic [3:0] PID_SETUP = 4'h2;
   localparam logic [3:0] PID_PING  = 4'hB;

   localparam logic [TIMEOUT_W-1:0] TMO = TIMEOUT_W'(RSP_TIMEOUT);

   typedef enum logic [3:0] {
      ST_IDLE, ST_WAIT_CTS, ST_PID, ST_B0, ST_B1,
      ST_STP, ST_WAIT_RSP, ST_RSP, ST_DONE
   } state_t;

   state_t state, state_nxt;

   logic [3:0]           pid_q;
   logic [10:0]          payload_q;
   logic [TIMEOUT_W-1:0] cnt_q;
   logic                 seen_q;
   logic                 err_q;
   logic                 rsp_valid_q;
   logic [3:0]           rsp_pid_q;
   logic                 rsp_pid_err_q;
   logic                 pid_ok;
   logic                 accept;
   logic                 wants_rsp;
   logic                 tmo_hit;
   logic [4:0]           crc5_tx;

   // CRC5 over the 11-bit payload, LSB first. The register's MSB goes on the
   // wire first, and since byte1 is itself sent LSB first the complemented
   // remainder is bit-reversed into crc5_tx.
   function automatic logic [4:0] crc5_calc(input logic [10:0] p);
      logic [4:0] c;
      logic [4:0] r;
      logic       fb;
      c = 5'h1F;
      for (int i = 0; i < 11; i++) begin
         fb = p[i] ^ c[4];
         c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
      end
      for (int i = 0; i < 5; i++) r[i] = ~c[4-i];
      return r;
   endfunction

   assign crc5_tx   = crc5_calc(payload_q);
   assign pid_ok    = (tok_pid == PID_OUT) || (tok_pid == PID_IN) ||
                      (tok_pid == PID_SOF) || (tok_pid == PID_SETUP) ||
                      (tok_pid == PID_PING);
   assign accept    = (state == ST_IDLE) && tok_req && pid_ok;
   assign wants_rsp = (pid_q == PID_IN) || (pid_q == PID_PING);
   assign tmo_hit   = (cnt_q == TMO);

   // State register
   always_ff @(posedge phy_clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:     if (accept) state_nxt = ST_WAIT_CTS;
         ST_WAIT_CTS: if (out_cts) state_nxt = ST_PID;
         ST_PID:      if (out_nxt) state_nxt = ST_B0;
         ST_B0:       if (out_nxt) state_nxt = ST_B1;
         ST_B1:       if (out_nxt) state_nxt = ST_STP;
         ST_STP:      state_nxt = wants_rsp ? ST_WAIT_RSP : ST_DONE;
         // Timeout is checked first so it wins a same-cycle in_act.
         ST_WAIT_RSP: if (tmo_hit) state_nxt = ST_DONE;
                      else if (in_act) state_nxt = ST_RSP;
         ST_RSP:      if (!in_act) state_nxt = ST_DONE;
         ST_DONE:     state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   // Output logic: all transmit outputs decode from state so a reset clears
   // them immediately.
   always_comb begin
      tok_busy    = (state != ST_IDLE) && (state != ST_DONE);
      tok_done    = (state == ST_DONE);
      out_latch   = (state == ST_PID) || (state == ST_B0) || (state == ST_B1);
      out_stp     = (state == ST_STP);
      out_byte    = 8'h00;
      case (state)
         ST_PID:  out_byte = {4'h4, ~pid_q};
         ST_B0:   out_byte = payload_q[7:0];
         ST_B1:   out_byte = {crc5_tx, payload_q[10:8]};
         default: out_byte = 8'h00;
      endcase
      // A receive that ends without any byte counts as no response.
      rsp_timeout = ((state == ST_WAIT_RSP) && tmo_hit) ||
                    ((state == ST_RSP) && !in_act && !in_latch && !seen_q);
      err_bad_req = err_q;
      rsp_valid   = rsp_valid_q;
      rsp_pid     = rsp_pid_q;
      rsp_pid_err = rsp_pid_err_q;
   end

   // Datapath: request latch, timeout counter, response capture.
   always_ff @(posedge phy_clk or posedge reset) begin
      if (reset) begin
         pid_q         <= 4'h0;
         payload_q     <= 11'h000;
         cnt_q         <= '0;
         seen_q        <= 1'b0;
         err_q         <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_pid_q     <= 4'h0;
         rsp_pid_err_q <= 1'b0;
      end else begin
         err_q       <= (state == ST_IDLE) && tok_req && !pid_ok;
         rsp_valid_q <= 1'b0;
         if (accept) begin
            pid_q     <= tok_pid;
            payload_q <= (tok_pid == PID_SOF) ? tok_frame : {tok_endp, tok_addr};
         end
         // The out_stp cycle counts as zero, so the counter equals the number
         // of cycles elapsed since out_stp while waiting.
         case (state)
            ST_IDLE:     cnt_q <= '0;
            ST_STP:      cnt_q <= TIMEOUT_W'(1);
            ST_WAIT_RSP: cnt_q <= cnt_q + 1'b1;
            default:     cnt_q <= cnt_q;
         endcase
         if (state == ST_STP) seen_q <= 1'b0;
         if ((state == ST_RSP) && in_latch && !seen_q) begin
            seen_q        <= 1'b1;
            rsp_valid_q   <= 1'b1;
            rsp_pid_q     <= in_byte[7:4];
            rsp_pid_err_q <= (in_byte[7:4] != ~in_byte[3:0]);
         end
      end
   end

endmodule

// File: tb/tb_usb2_host_token_tx.sv
// Testbench for usb2_host_token_tx: directed token vectors with hand-computed
// byte streams; a monitor pops expected events from a queue.
// Event word: {type[3:0], data[7:0]}; 1=byte accepted, 2=out_stp,
// 3=rsp_valid {3'b0,err,pid}, 4=rsp_timeout, 5=err_bad_req, 6=tok_done.
module tb_usb2_host_token_tx;

   logic        phy_clk = 1'b0;
   logic        reset;
   logic        tok_req;
   logic [3:0]  tok_pid;
   logic [6:0]  tok_addr;
   logic [3:0]  tok_endp;
   logic [10:0] tok_frame;
   logic        tok_busy, tok_done, err_bad_req;
   logic        out_cts, out_nxt;
   logic [7:0]  out_byte;
   logic        out_latch, out_stp;
   logic        in_act;
   logic [7:0]  in_byte;
   logic        in_latch;
   logic        rsp_valid;
   logic [3:0]  rsp_pid;
   logic        rsp_pid_err, rsp_timeout;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int stall_n = 0;
   int stp_cyc = 0;
   int tmo_cyc = 0;
   int done_cyc = 0;
   int req_cyc = 0;

   logic [11:0] exp_q[$];

   usb2_host_token_tx #(.RSP_TIMEOUT(120), .TIMEOUT_W(8)) dut (
      .phy_clk(phy_clk), .reset(reset),
      .tok_req(tok_req), .tok_pid(tok_pid), .tok_addr(tok_addr),
      .tok_endp(tok_endp), .tok_frame(tok_frame),
      .tok_busy(tok_busy), .tok_done(tok_done), .err_bad_req(err_bad_req),
      .out_cts(out_cts), .out_nxt(out_nxt), .out_byte(out_byte),
      .out_latch(out_latch), .out_stp(out_stp),
      .in_act(in_act), .in_byte(in_byte), .in_latch(in_latch),
      .rsp_valid(rsp_valid), .rsp_pid(rsp_pid), .rsp_pid_err(rsp_pid_err),
      .rsp_timeout(rsp_timeout)
   );

   // Clock / cycle counter
   always #8 phy_clk = ~phy_clk;
   always @(posedge phy_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // PHY transmit side: out_nxt is withheld for stall_n cycles on each byte.
   initial begin : phy_nxt
      int wcnt;
      wcnt = 0;
      out_nxt = 1'b0;
      forever begin
         @(posedge phy_clk);
         #1;
         if (out_latch) begin
            if (wcnt >= stall_n) begin
               out_nxt = 1'b1;
               wcnt = 0;
            end else begin
               out_nxt = 1'b0;
               wcnt++;
            end
         end else begin
            out_nxt = 1'b0;
            wcnt = 0;
         end
      end
   end

   // Monitor / scoreboard
   task automatic pop_ev(input string name, input logic [11:0] got);
      logic [11:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL %s: unexpected event %h, none expected (cycle %0d)", name, got, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e !== got) begin
            failures++;
            $display("FAIL %s: got event %h expected %h (cycle %0d)", name, got, e, cyc);
         end
      end
   endtask

   initial begin : monitor
      logic       prev_hold;
      logic [7:0] prev_byte;
      prev_hold = 1'b0;
      prev_byte = 8'h00;
      forever begin
         @(negedge phy_clk);
         if (reset) begin
            prev_hold = 1'b0;
         end else begin
            if (prev_hold)
               check("byte_hold", {7'd0, out_latch, out_byte}, {7'd0, 1'b1, prev_byte});
            if (out_latch && out_nxt) pop_ev("tx_byte", {4'h1, out_byte});
            if (out_stp) begin
               stp_cyc = cyc;
               pop_ev("out_stp", 12'h200);
            end
            if (rsp_valid) pop_ev("rsp_valid", {4'h3, 3'b000, rsp_pid_err, rsp_pid});
            if (rsp_timeout) begin
               tmo_cyc = cyc;
               pop_ev("rsp_timeout", 12'h400);
            end
            if (err_bad_req) pop_ev("err_bad_req", 12'h500);
            if (tok_done) begin
               done_cyc = cyc;
               pop_ev("tok_done", 12'h600);
            end
            prev_hold = out_latch && !out_nxt;
            prev_byte = out_byte;
         end
      end
   end

   // Driver tasks
   task automatic issue(input logic [3:0] pid, input logic [6:0] addr,
                        input logic [3:0] endp, input logic [10:0] frame);
      @(posedge phy_clk);
      #1;
      tok_pid = pid; tok_addr = addr; tok_endp = endp; tok_frame = frame;
      tok_req = 1'b1;
      req_cyc = cyc;
      @(posedge phy_clk);
      #1;
      tok_req = 1'b0;
   endtask

   task automatic push3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      exp_q.push_back({4'h1, b0});
      exp_q.push_back({4'h1, b1});
      exp_q.push_back({4'h1, b2});
      exp_q.push_back(12'h200);
   endtask

   task automatic wait_done(input int max_cyc, input string name);
      bit got;
      got = 1'b0;
      for (int i = 0; i < max_cyc && !got; i++) begin
         @(negedge phy_clk);
         if (tok_done) got = 1'b1;
      end
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL %s: tok_done not seen within %0d cycles", name, max_cyc);
      end
   endtask

   task automatic wait_stp(input int max_cyc, input string name);
      bit got;
      got = 1'b0;
      for (int i = 0; i < max_cyc && !got; i++) begin
         @(negedge phy_clk);
         if (out_stp) got = 1'b1;
      end
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL %s: out_stp not seen within %0d cycles", name, max_cyc);
      end
   endtask

   initial begin : stimulus
      bit got;
      reset = 1'b1;
      tok_req = 1'b0; tok_pid = 4'h0; tok_addr = 7'h0; tok_endp = 4'h0; tok_frame = 11'h0;
      out_cts = 1'b1; in_act = 1'b0; in_byte = 8'h00; in_latch = 1'b0;

      // Reset state
      repeat (3) @(negedge phy_clk);
      check("rst_out_byte", {8'h0, out_byte}, 16'h0000);
      check("rst_flags", {9'd0, tok_busy, tok_done, out_latch, out_stp, rsp_valid,
                          rsp_timeout, err_bad_req}, 16'h0000);
      check("rst_rsp_pid", {11'd0, rsp_pid_err, rsp_pid}, 16'h0000);
      @(negedge phy_clk);
      reset = 1'b0;

      // 1: SETUP addr 0 endp 0, no stalls; minimum latency
      stall_n = 0;
      push3(8'h4D, 8'h00, 8'h10);
      exp_q.push_back(12'h600);
      issue(4'h2, 7'h00, 4'h0, 11'h0);
      wait_done(40, "setup_done");
      check("setup_stp_lat", 16'(stp_cyc - req_cyc), 16'd5);
      check("setup_done_lat", 16'(done_cyc - req_cyc), 16'd6);

      // 2: IN addr 0 endp 0, cts held off, 3-cycle stalls, NAK reply
      stall_n = 3;
      out_cts = 1'b0;
      push3(8'h49, 8'h00, 8'h10);
      exp_q.push_back({4'h3, 8'h05});
      exp_q.push_back(12'h600);
      issue(4'h6, 7'h00, 4'h0, 11'h0);
      @(posedge phy_clk); #1;
      check("in_busy", {15'd0, tok_busy}, 16'd1);
      tok_pid = 4'h2; tok_req = 1'b1;        // overlapping request, ignored
      @(posedge phy_clk); #1;
      tok_req = 1'b0;
      repeat (2) @(posedge phy_clk);
      #1 out_cts = 1'b1;
      wait_stp(60, "in_stp");
      repeat (10) @(posedge phy_clk);
      #1 in_act = 1'b1;
      @(posedge phy_clk); #1 in_latch = 1'b1; in_byte = 8'h5A;
      @(posedge phy_clk); #1 in_byte = 8'hC3; // trailing byte, ignored
      @(posedge phy_clk); #1 in_latch = 1'b0; in_byte = 8'h00;
      @(posedge phy_clk); #1 in_act = 1'b0;
      wait_done(20, "in_done");
      check("in_done_after_act", {15'd0, done_cyc > cyc - 3}, 16'd1);
      check("in_rsp_pid", {12'd0, rsp_pid}, 16'h0005);

      // 3: PING addr 1 endp 0, no reply -> timeout 120 cycles after out_stp
      stall_n = 0;
      push3(8'h44, 8'h01, 8'hE8);
      exp_q.push_back(12'h400);
      exp_q.push_back(12'h600);
      issue(4'hB, 7'h01, 4'h0, 11'h0);
      wait_done(300, "ping_done");
      check("ping_tmo_delay", 16'(tmo_cyc - stp_cyc), 16'd120);
      check("ping_rsp_pid_hold", {12'd0, rsp_pid}, 16'h0005);

      // 4: SOF frame 7FF then 0; OUT addr 1 endp 0
      push3(8'h45, 8'hFF, 8'h47);
      exp_q.push_back(12'h600);
      issue(4'hA, 7'h00, 4'h0, 11'h7FF);
      wait_done(40, "sof7ff_done");
      push3(8'h45, 8'h00, 8'h10);
      exp_q.push_back(12'h600);
      issue(4'hA, 7'h7F, 4'hF, 11'h000);
      wait_done(40, "sof0_done");
      push3(8'h41, 8'h01, 8'hE8);
      exp_q.push_back(12'h600);
      issue(4'hE, 7'h01, 4'h0, 11'h0);
      wait_done(40, "out_done");

      // 5: non-token PID
      exp_q.push_back(12'h500);
      issue(4'hD, 7'h05, 4'h1, 11'h0);
      for (int i = 0; i < 4; i++) begin
         @(negedge phy_clk);
         check("bad_busy", {14'd0, tok_busy, out_latch}, 16'd0);
      end

      // 6: reset during byte0, then a clean SETUP
      stall_n = 3;
      exp_q.push_back(12'h14D);
      issue(4'h2, 7'h00, 4'h0, 11'h0);
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge phy_clk);
         if (out_latch && out_nxt && out_byte == 8'h4D) got = 1'b1;
      end
      check("rst_mid_reach_b0", {15'd0, got}, 16'd1);
      @(posedge phy_clk);
      #1 check("b0_before_rst", {7'd0, out_latch, out_byte}, {7'd0, 1'b1, 8'h00});
      #1 reset = 1'b1;
      #1;
      check("rst_mid_latch", {7'd0, out_latch, out_byte}, 16'h0000);
      check("rst_mid_busy", {14'd0, tok_busy, out_stp}, 16'd0);
      @(negedge phy_clk);
      @(negedge phy_clk);
      reset = 1'b0;
      stall_n = 0;
      push3(8'h4D, 8'h00, 8'h10);
      exp_q.push_back(12'h600);
      issue(4'h2, 7'h00, 4'h0, 11'h0);
      wait_done(40, "setup2_done");

      repeat (4) @(negedge phy_clk);
      check("queue_empty", 16'(exp_q.size()), 16'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
